// File: rtl/wb_port_arbiter_pkg.sv
// Types, widths and pointer helper shared by the writeback arbiter and its sub-block.
package wb_port_arbiter_pkg;
  localparam int unsigned NREQ = 3;
  localparam int unsigned RW   = 5;
  localparam int unsigned DW   = 32;

  typedef enum logic {ST_IDLE, ST_WRITE} wb_state_e;
  typedef logic [1:0] ptr_t;

  function automatic ptr_t ptr_after(input ptr_t idx);
    return (idx == 2'd2) ? 2'd0 : idx + 2'd1;
  endfunction
endpackage

// File: rtl/wb_port_arbiter_rr.sv
// rr_arbiter_3: combinational round-robin pick over three requesters.
// Search order starts at i_ptr and wraps; o_gnt is one-hot or zero.
module rr_arbiter_3
  import wb_port_arbiter_pkg::*;
(
  input  logic [2:0] i_vld,
  input  ptr_t       i_ptr,
  output logic [2:0] o_gnt
);
  always_comb begin
    o_gnt = 3'b000;
    case (i_ptr)
      2'd1: begin
        if      (i_vld[1]) o_gnt = 3'b010;
        else if (i_vld[2]) o_gnt = 3'b100;
        else if (i_vld[0]) o_gnt = 3'b001;
      end
      2'd2: begin
        if      (i_vld[2]) o_gnt = 3'b100;
        else if (i_vld[0]) o_gnt = 3'b001;
        else if (i_vld[1]) o_gnt = 3'b010;
      end
      default: begin
        if      (i_vld[0]) o_gnt = 3'b001;
        else if (i_vld[1]) o_gnt = 3'b010;
        else if (i_vld[2]) o_gnt = 3'b100;
      end
    endcase
  end
endmodule

// File: rtl/wb_port_arbiter.sv
// Writeback port arbiter: 3 requesters share one register-file write port, 1-cycle registered write.
// Optional register busy scoreboard enabled by WB_SCOREBOARD_EN.
module wb_port_arbiter
  import wb_port_arbiter_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NREQ-1:0]         req_valid,
  input  logic [NREQ-1:0][RW-1:0] req_rd,
  input  logic [NREQ-1:0][DW-1:0] req_data,
  output logic [NREQ-1:0]         req_ready,
  input  logic                    wb_stall,
  output logic [RW-1:0]           reg_write,
  output logic [DW-1:0]           data_write
`ifdef WB_SCOREBOARD_EN
  ,
  input  logic                    issue_valid,
  input  logic [RW-1:0]           issue_rd,
  output logic [31:0]             busy_mask
`endif
);
  wb_state_e     r_state;
  wb_state_e     w_state_nxt;
  ptr_t          r_ptr;
  logic [RW-1:0] r_rd;
  logic [DW-1:0] r_dat;

  logic [NREQ-1:0] w_rd_nz;
  logic [NREQ-1:0] w_arb_vld;
  logic [NREQ-1:0] w_gnt;
  logic            w_grant;
  logic            w_load;
  ptr_t            w_win_idx;
  logic [RW-1:0]   w_win_rd;
  logic [DW-1:0]   w_win_dat;

  for (genvar g = 0; g < NREQ; g++) begin : g_rdnz
    assign w_rd_nz[g] = |req_rd[g];
  end

  // rd==0 requests bypass arbitration and are acked immediately, even under stall.
  assign w_arb_vld = (rst || wb_stall) ? '0 : (req_valid & w_rd_nz);
  assign req_ready = rst ? '0 : (w_gnt | (req_valid & ~w_rd_nz));
  assign w_grant   = |w_gnt;

  rr_arbiter_3 u_rr (
    .i_vld (w_arb_vld),
    .i_ptr (r_ptr),
    .o_gnt (w_gnt)
  );

  always_comb begin
    case (w_gnt)
      3'b010:  w_win_idx = 2'd1;
      3'b100:  w_win_idx = 2'd2;
      default: w_win_idx = 2'd0;
    endcase
    w_win_rd  = req_rd[w_win_idx];
    w_win_dat = req_data[w_win_idx];
  end

  always_comb begin
    w_state_nxt = ST_IDLE;
    w_load      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_grant) begin
          w_state_nxt = ST_WRITE;
          w_load      = 1'b1;
        end
      end
      ST_WRITE: begin
        if (w_grant) begin
          w_state_nxt = ST_WRITE;
          w_load      = 1'b1;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_ptr   <= 2'd0;
      r_rd    <= '0;
      r_dat   <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_load) begin
        r_rd  <= w_win_rd;
        r_dat <= w_win_dat;
        r_ptr <= ptr_after(w_win_idx);
      end
    end
  end

  // A pending write vanishes the instant reset clears the state register.
  assign reg_write  = (r_state == ST_WRITE) ? r_rd  : '0;
  assign data_write = (r_state == ST_WRITE) ? r_dat : '0;

`ifdef WB_SCOREBOARD_EN
  logic [31:0] r_busy;
  logic [31:0] w_set;
  logic [31:0] w_clr;

  always_comb begin
    w_set = '0;
    w_clr = '0;
    if (issue_valid) w_set[issue_rd] = 1'b1;
    w_clr[reg_write] = 1'b1;
    w_set[0] = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_busy <= '0;
    else     r_busy <= ((r_busy & ~w_clr) | w_set) & ~32'd1;
  end

  assign busy_mask = r_busy;
`endif
endmodule

// File: tb/tb_wb_port_arbiter.sv
// Bench for wb_port_arbiter: vector table with write scoreboard, plus reset and scoreboard sequences.
module tb_wb_port_arbiter;
  import wb_port_arbiter_pkg::*;

  logic                    clk = 1'b0;
  logic                    rst;
  logic [2:0]              req_valid;
  logic [2:0][RW-1:0]      req_rd;
  logic [2:0][DW-1:0]      req_data;
  logic [2:0]              req_ready;
  logic                    wb_stall;
  logic [RW-1:0]           reg_write;
  logic [DW-1:0]           data_write;
`ifdef WB_SCOREBOARD_EN
  logic                    issue_valid;
  logic [RW-1:0]           issue_rd;
  logic [31:0]             busy_mask;
`endif

  always #5 clk = ~clk;

  wb_port_arbiter dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_rd     (req_rd),
    .req_data   (req_data),
    .req_ready  (req_ready),
    .wb_stall   (wb_stall),
    .reg_write  (reg_write),
    .data_write (data_write)
`ifdef WB_SCOREBOARD_EN
    ,
    .issue_valid(issue_valid),
    .issue_rd   (issue_rd),
    .busy_mask  (busy_mask)
`endif
  );

  typedef struct {
    logic [2:0]    vld;
    logic [RW-1:0] rd0, rd1, rd2;
    logic          stall;
    logic [2:0]    exp_rdy;
    logic [RW-1:0] exp_rd;
    int            exp_win;
  } vec_t;

  typedef struct {
    logic [RW-1:0] rd;
    logic [DW-1:0] dat;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];
  int   n_vec = 0;
  int   n_err = 0;

  function automatic logic [DW-1:0] mkd(input int i, input logic [RW-1:0] rd);
    return DW'(32'hA000_0000) | DW'(i * 4096) | DW'(rd);
  endfunction

  function automatic vec_t mk(input logic [2:0] v, input int r0, input int r1, input int r2,
                              input logic st, input logic [2:0] er, input int erd, input int ew);
    vec_t x;
    x.vld = v; x.rd0 = RW'(r0); x.rd1 = RW'(r1); x.rd2 = RW'(r2);
    x.stall = st; x.exp_rdy = er; x.exp_rd = RW'(erd); x.exp_win = ew;
    return x;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic [2:0] v, input logic [RW-1:0] r0, input logic [RW-1:0] r1,
                       input logic [RW-1:0] r2, input logic st);
    req_valid = v;
    req_rd[0] = r0; req_rd[1] = r1; req_rd[2] = r2;
    req_data[0] = mkd(0, r0); req_data[1] = mkd(1, r1); req_data[2] = mkd(2, r2);
    wb_stall = st;
  endtask

  task automatic apply(input vec_t v, input int k);
    exp_t e;
    exp_t got;
    @(negedge clk);
    drive(v.vld, v.rd0, v.rd1, v.rd2, v.stall);
    #1;
    chk($sformatf("v%0d_ready", k), 32'(req_ready), 32'(v.exp_rdy));
    e.rd  = v.exp_rd;
    e.dat = (v.exp_rd != 0) ? mkd(v.exp_win, v.exp_rd) : '0;
    sb.push_back(e);
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      chk($sformatf("v%0d_sb_empty", k), 32'd0, 32'd1);
    end else begin
      got = sb.pop_front();
      chk($sformatf("v%0d_reg_write", k), 32'(reg_write), 32'(got.rd));
      if (got.rd != 0) chk($sformatf("v%0d_data_write", k), 32'(data_write), 32'(got.dat));
    end
  endtask

  initial begin
    rst = 1'b1;
    drive(3'b111, 5, 6, 7, 1'b0);
`ifdef WB_SCOREBOARD_EN
    issue_valid = 1'b1;
    issue_rd    = 5'd3;
`endif
    #1;
    chk("reset_ready", 32'(req_ready), 32'd0);
    chk("reset_reg_write", 32'(reg_write), 32'd0);
    chk("reset_data_write", 32'(data_write), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    chk("reset_hold_reg_write", 32'(reg_write), 32'd0);
`ifdef WB_SCOREBOARD_EN
    chk("reset_busy", busy_mask, 32'd0);
    issue_valid = 1'b0;
`endif
    @(negedge clk);
    drive(3'b000, 0, 0, 0, 1'b0);
    rst = 1'b0;

    // in-order grants from reset
    vecs.push_back(mk(3'b111, 5, 6, 7, 0, 3'b001, 5, 0));
    vecs.push_back(mk(3'b110, 5, 6, 7, 0, 3'b010, 6, 1));
    vecs.push_back(mk(3'b100, 5, 6, 7, 0, 3'b100, 7, 2));
    vecs.push_back(mk(3'b000, 0, 0, 0, 0, 3'b000, 0, 0));
    // rd==0 bypass, then ptr must be 2
    vecs.push_back(mk(3'b011, 0, 9, 0, 0, 3'b011, 9, 1));
    vecs.push_back(mk(3'b111, 1, 2, 3, 0, 3'b100, 3, 2));
    // stall holds grants and ptr
    vecs.push_back(mk(3'b100, 0, 0, 4, 1, 3'b000, 0, 0));
    vecs.push_back(mk(3'b100, 0, 0, 4, 1, 3'b000, 0, 0));
    vecs.push_back(mk(3'b100, 0, 0, 4, 1, 3'b000, 0, 0));
    vecs.push_back(mk(3'b100, 0, 0, 4, 0, 3'b100, 4, 2));
    vecs.push_back(mk(3'b001, 0, 0, 0, 1, 3'b001, 0, 0));
    vecs.push_back(mk(3'b111, 0, 0, 0, 0, 3'b111, 0, 0));
    // fairness: 0 and 1 alternate
    vecs.push_back(mk(3'b011, 1, 2, 0, 0, 3'b001, 1, 0));
    vecs.push_back(mk(3'b011, 1, 2, 0, 0, 3'b010, 2, 1));
    vecs.push_back(mk(3'b011, 1, 2, 0, 0, 3'b001, 1, 0));
    vecs.push_back(mk(3'b011, 1, 2, 0, 0, 3'b010, 2, 1));
    vecs.push_back(mk(3'b000, 0, 0, 0, 0, 3'b000, 0, 0));

    for (int k = 0; k < vecs.size(); k++) apply(vecs[k], k);

    // grant then async reset before the write retires; ptr would be 1 without reset
    @(negedge clk);
    drive(3'b001, 8, 0, 0, 1'b0);
    #1;
    chk("rst_seq_ready", 32'(req_ready), 32'b001);
    @(posedge clk);
    #1;
    chk("rst_seq_write", 32'(reg_write), 32'd8);
    #2 rst = 1'b1;
    #1;
    chk("rst_seq_drop_rd", 32'(reg_write), 32'd0);
    chk("rst_seq_drop_dat", 32'(data_write), 32'd0);
    chk("rst_seq_ready_low", 32'(req_ready), 32'd0);
    @(posedge clk);
    #1;
    chk("rst_seq_no_write", 32'(reg_write), 32'd0);
    @(negedge clk);
    drive(3'b000, 0, 0, 0, 1'b0);
    rst = 1'b0;
    apply(mk(3'b011, 1, 2, 0, 0, 3'b001, 1, 0), 100);
    apply(mk(3'b000, 0, 0, 0, 0, 3'b000, 0, 0), 101);

`ifdef WB_SCOREBOARD_EN
    @(negedge clk);
    issue_valid = 1'b1; issue_rd = 5'd12;
    @(posedge clk); #1;
    chk("sb_set", busy_mask, 32'h1 << 12);
    @(negedge clk);
    issue_valid = 1'b0;
    drive(3'b001, 12, 0, 0, 1'b0);
    @(posedge clk); #1;
    chk("sb_wr12", 32'(reg_write), 32'd12);
    chk("sb_still_busy", busy_mask, 32'h1 << 12);
    @(negedge clk);
    drive(3'b000, 0, 0, 0, 1'b0);
    @(posedge clk); #1;
    chk("sb_cleared", busy_mask, 32'd0);
    @(negedge clk);
    drive(3'b001, 12, 0, 0, 1'b0);
    @(posedge clk); #1;
    chk("sb_wr12_again", 32'(reg_write), 32'd12);
    @(negedge clk);
    drive(3'b000, 0, 0, 0, 1'b0);
    issue_valid = 1'b1; issue_rd = 5'd12;
    @(posedge clk); #1;
    chk("sb_set_wins", busy_mask, 32'h1 << 12);
    @(negedge clk);
    issue_rd = 5'd0;
    @(posedge clk); #1;
    chk("sb_bit0_zero", busy_mask, 32'h1 << 12);
    @(negedge clk);
    issue_valid = 1'b0;
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
